multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control finite-state machine for the multi-cycle datapath. It sequences every instruction through fetch, decode, execute, memory and write-back. It drives all datapath enables, and it produces the 3-bit `alu_OP` consumed by `alu_control`: `011` means R-type, so use `func`; any other value is passed straight through as the ALU select. It also handles the memory wait handshake and counts retired instructions.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `opcode` input 4: `instr[15:12]` from the instruction register.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current read or write this cycle.
- `alu_OP` output 3: to `alu_control`.
- `alu_src_a` output 1: 0 selects PC, 1 selects reg A.
- `alu_src_b` output 2: 00 selects reg B, 01 selects constant 1, 10 selects sign-extended immediate, 11 selects sign-extended branch offset.
- `iord` output 1: memory address source; 0 selects PC, 1 selects ALUOut.
- `mem_read` output 1.
- `mem_write` output 1.
- `ir_write` output 1.
- `pc_write` output 1.
- `pc_src` output 2: 00 selects ALU result, 01 selects ALUOut (branch target), 10 selects jump target.
- `reg_write` output 1.
- `reg_dst` output 1: 1 selects rd.
- `mem_to_reg` output 1.
- `illegal` output 1.
- `retired` output 16: retired-instruction count.
- `state` output 3: debug view of the state register.

## Operation
- Opcode decode, with the ALU op each uses in EXEC:
  - `0000` R-type: `011`.
  - `0001` addi: `000`.
  - `0010` andi: `110`.
  - `0011` ori: `111`.
  - `0100` lw: `000`.
  - `0101` sw: `000`.
  - `0110` beq: `010`.
  - `0111` j: no ALU op.
  - `1000`–`1111`: illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5. Codes 6 and 7 are unreachable; if entered, the next state is FETCH.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_OP`=000.
  - If `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE.
  - Otherwise stay in FETCH with `ir_write` and `pc_write` low.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_OP`=000 (branch target into ALUOut).
  - Latches `opcode` into an internal `op_q`; `op_q` drives all later states.
  - j: `pc_write`=1, `pc_src`=10, go to FETCH (retires).
  - Illegal opcode: `illegal`=1 for this cycle, go to FETCH; the instruction is not retired.
  - All other opcodes go to EXEC.
- EXEC:
  - Drives `alu_src_a`=1 and `alu_OP` from the table.
  - R-type and beq use `alu_src_b`=00; all other opcodes use `alu_src_b`=10.
  - beq: `pc_src`=01, `pc_write`=`zero`, go to FETCH (retires whether taken or not).
  - lw goes to MEM_RD, sw goes to MEM_WR, everything else goes to WB.
- MEM_RD:
  - Drives `mem_read`=1, `iord`=1.
  - Holds until `mem_ready`, then goes to WB.
- MEM_WR:
  - Drives `mem_write`=1, `iord`=1.
  - Holds until `mem_ready`, then goes to FETCH (retires).
- WB:
  - Drives `reg_write`=1.
  - `reg_dst`=1 if `op_q` is R-type; `mem_to_reg`=1 if `op_q` is lw.
  - Goes to FETCH (retires).
- `retired` increments by 1 on each retiring transition into FETCH and wraps 0xFFFF→0x0000.
- `alu_OP` is never 011 except for an R-type in EXEC.

## Timing
- Outputs are combinational from `state`, `op_q`, `opcode` (DECODE only), `zero` and `mem_ready`. State, `op_q` and `retired` are registered.
- Reset:
  - While `reset` is high, every output is 0 regardless of state.
  - On the edge with `reset` high: `state`=FETCH, `op_q`=0000, `retired`=0.
  - Reset mid-instruction abandons that instruction without a retire or write. The first post-reset cycle is FETCH.
- Cycles per instruction with zero wait states:
  - j: 2.
  - beq: 3.
  - R-type, addi, andi, ori, sw: 4.
  - lw: 5.
  - Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- `mem_ready` is ignored in DECODE, EXEC and WB.
- `mem_read` and `mem_write` are never high in the same cycle.
- `pc_write` and `reg_write` are never high in the same cycle.

## Test plan
- Reset: hold `reset` for 2 cycles in the middle of MEM_WR.
  - Required: all outputs 0 during reset; then `state`=0, `retired`=0; `mem_write` low from the first reset cycle.
- R-type `0000`, `mem_ready`=1: states 0,1,2,5,0.
  - EXEC: `alu_OP`=011, `alu_src_b`=00.
  - WB: `reg_write`=1, `reg_dst`=1.
  - `retired` goes 0→1.
- lw `0100` with `mem_ready` low for 2 cycles in MEM_RD:
  - States 0,1,2,3,3,3,5,0 (8 cycles).
  - WB: `mem_to_reg`=1.
- beq `0110`:
  - `zero`=1: EXEC shows `alu_OP`=010, `pc_write`=1, `pc_src`=01.
  - `zero`=0: `pc_write`=0.
  - Both cases take 3 cycles and retire.
- j `0111`, then illegal `1010`:
  - j: DECODE `pc_write`=1, `pc_src`=10.
  - Illegal: DECODE `illegal`=1, next state FETCH, `retired` unchanged.
- Counter wrap: 65536 consecutive j instructions with `mem_ready`=1.
  - Required: `retired` returns to 0x0000 one retire after 0xFFFF.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM of the multi-cycle datapath. Each instruction is walked
// through FETCH, DECODE, EXEC, MEM_RD/MEM_WR and WB. The FSM drives every
// datapath enable and the 3-bit ALU op, and it counts retired instructions.
// Outputs are combinational from the state, the latched opcode and the
// handshake inputs. Every output is forced to zero while reset is high.

module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  alu_OP,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [15:0] retired,
  output logic [2:0]  state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_J     = 4'b0111;

  logic [2:0]  state_r;
  logic [3:0]  op_q_r;
  logic [15:0] retired_r;
  logic [2:0]  next_state_s;
  logic        retire_s;

  // ALU op used in EXEC. Only an R-type yields 011 (use func); the rest are
  // direct ALU selects. j and illegal opcodes never reach EXEC.
  function automatic logic [2:0] exec_alu_op(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      4'b0000: sel = 3'b011;
      4'b0010: sel = 3'b110;
      4'b0011: sel = 3'b111;
      4'b0110: sel = 3'b010;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

  // Opcodes 1xxx are undefined.
  function automatic logic is_illegal(input logic [3:0] op);
    return op[3];
  endfunction

  // R-type and beq take the second ALU operand from reg B, others use the immediate.
  function automatic logic [1:0] exec_src_b(input logic [3:0] op);
    logic [1:0] sel;
    if ((op == OP_RTYPE) || (op == OP_BEQ)) begin
      sel = 2'b00;
    end else begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Next-state, retire strobe and all datapath controls for the current state.
  always_comb begin
    next_state_s = S_FETCH;
    retire_s     = 1'b0;
    alu_OP       = 3'b000;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;
    if (reset) begin
      next_state_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            next_state_s = S_DECODE;
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_DECODE: begin
          // Branch target PC + offset goes into ALUOut while decoding.
          alu_src_b = 2'b11;
          if (opcode == OP_J) begin
            pc_write     = 1'b1;
            pc_src       = 2'b10;
            retire_s     = 1'b1;
            next_state_s = S_FETCH;
          end else if (is_illegal(opcode)) begin
            illegal      = 1'b1;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_OP    = exec_alu_op(op_q_r);
          alu_src_b = exec_src_b(op_q_r);
          if (op_q_r == OP_BEQ) begin
            pc_src       = 2'b01;
            pc_write     = zero;
            retire_s     = 1'b1;
            next_state_s = S_FETCH;
          end else if (op_q_r == OP_LW) begin
            next_state_s = S_MEM_RD;
          end else if (op_q_r == OP_SW) begin
            next_state_s = S_MEM_WR;
          end else begin
            next_state_s = S_WB;
          end
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            next_state_s = S_WB;
          end else begin
            next_state_s = S_MEM_RD;
          end
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            retire_s     = 1'b1;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_MEM_WR;
          end
        end
        S_WB: begin
          reg_write    = 1'b1;
          reg_dst      = (op_q_r == OP_RTYPE);
          mem_to_reg   = (op_q_r == OP_LW);
          retire_s     = 1'b1;
          next_state_s = S_FETCH;
        end
        default: begin
          // Codes 6 and 7 are unreachable; recover to FETCH with no side effects.
          next_state_s = S_FETCH;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Opcode latch: captured in DECODE and used by every later state.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q_r <= 4'b0000;
    end else if (state_r == S_DECODE) begin
      op_q_r <= opcode;
    end else begin
      op_q_r <= op_q_r;
    end
  end

  // Retired-instruction counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_r <= 16'd0;
    end else if (retire_s) begin
      retired_r <= retired_r + 16'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Debug views, blanked while reset is asserted.
  always_comb begin
    if (reset) begin
      state   = 3'd0;
      retired = 16'd0;
    end else begin
      state   = state_r;
      retired = retired_r;
    end
  end

  multicycle_control_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .state     (state_r),
    .op_q      (op_q_r),
    .alu_OP    (alu_OP),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .pc_write  (pc_write),
    .reg_write (reg_write)
  );

endmodule

// Invariants of the control FSM; has no effect on the hardware.
module multicycle_control_chk (
  input logic       clk,
  input logic       reset,
  input logic [2:0] state,
  input logic [3:0] op_q,
  input logic [2:0] alu_OP,
  input logic       mem_read,
  input logic       mem_write,
  input logic       pc_write,
  input logic       reg_write
);

  a_mem_excl: assert property (@(posedge clk) !(mem_read && mem_write));

  a_wr_excl: assert property (@(posedge clk) !(pc_write && reg_write));

  a_rtype_only: assert property (@(posedge clk) disable iff (reset)
    (alu_OP == 3'b011) |-> ((state == 3'd2) && (op_q == 4'b0000)));

  a_state_legal: assert property (@(posedge clk) disable iff (reset)
    (state <= 3'd5));

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Instructions are expanded by a reference
// model into a per-cycle plan of inputs and expected outputs; the plan is then
// driven into the DUT and every cycle is compared.

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  alu_OP;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        illegal;
  logic [15:0] retired;
  logic [2:0]  state;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_OP     (alu_OP),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .retired    (retired),
    .state      (state)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       regw;
    logic       regdst;
    logic       m2r;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic [3:0]  opc;
    logic        z;
    logic        rdy;
    logic [2:0]  st;
    ctl_t        ctl;
    logic [15:0] ret;
  } cyc_t;

  cyc_t        plan[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_retired = 16'd0;
  ctl_t        ctl_obs;

  assign ctl_obs = {alu_OP, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                    ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [3:0] rnd4();
    logic [31:0] t;
    t = $urandom;
    return t[3:0];
  endfunction

  function automatic logic rnd1();
    logic [31:0] t;
    t = $urandom;
    return t[0];
  endfunction

  // ALU op an instruction uses in EXEC, straight from the opcode table.
  function automatic logic [2:0] table_alu_op(input logic [3:0] op);
    logic [2:0] r;
    case (op)
      4'd0:    r = 3'b011;
      4'd2:    r = 3'b110;
      4'd3:    r = 3'b111;
      4'd6:    r = 3'b010;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  task automatic push(input logic [2:0] st, input ctl_t c, input logic rdy,
                      input logic [3:0] opc, input logic z, input logic retire);
    cyc_t r;
    r.rst = 1'b0;
    r.opc = opc;
    r.z   = z;
    r.rdy = rdy;
    r.st  = st;
    r.ctl = c;
    r.ret = m_retired;
    plan.push_back(r);
    if (retire) begin
      m_retired = m_retired + 16'd1;
    end
  endtask

  task automatic push_reset();
    cyc_t r;
    m_retired = 16'd0;
    r.rst = 1'b1;
    r.opc = rnd4();
    r.z   = rnd1();
    r.rdy = 1'b1;
    r.st  = 3'd0;
    r.ctl = '0;
    r.ret = 16'd0;
    plan.push_back(r);
  endtask

  // Expand one instruction into its cycle sequence. fw/mw are the number of
  // not-ready cycles in FETCH and in the memory phase.
  task automatic add_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    ctl_t c;
    for (int i = 0; i < fw; i++) begin
      c = '0; c.mrd = 1'b1; c.src_b = 2'b01;
      push(3'd0, c, 1'b0, rnd4(), rnd1(), 1'b0);
    end
    c = '0; c.mrd = 1'b1; c.src_b = 2'b01; c.irw = 1'b1; c.pcw = 1'b1;
    push(3'd0, c, 1'b1, rnd4(), rnd1(), 1'b0);
    c = '0; c.src_b = 2'b11;
    if (op == 4'd7) begin
      c.pcw = 1'b1; c.pcsrc = 2'b10;
      push(3'd1, c, rnd1(), op, rnd1(), 1'b1);
      return;
    end
    if (op >= 4'd8) begin
      c.ill = 1'b1;
      push(3'd1, c, rnd1(), op, rnd1(), 1'b0);
      return;
    end
    push(3'd1, c, rnd1(), op, rnd1(), 1'b0);
    c = '0; c.src_a = 1'b1; c.alu_op = table_alu_op(op);
    c.src_b = ((op == 4'd0) || (op == 4'd6)) ? 2'b00 : 2'b10;
    if (op == 4'd6) begin
      c.pcsrc = 2'b01; c.pcw = z;
      push(3'd2, c, rnd1(), rnd4(), z, 1'b1);
      return;
    end
    push(3'd2, c, rnd1(), rnd4(), rnd1(), 1'b0);
    if (op == 4'd4 || op == 4'd5) begin
      c = '0; c.iord = 1'b1;
      if (op == 4'd4) c.mrd = 1'b1; else c.mwr = 1'b1;
      for (int i = 0; i < mw; i++) begin
        push((op == 4'd4) ? 3'd3 : 3'd4, c, 1'b0, rnd4(), rnd1(), 1'b0);
      end
      push((op == 4'd4) ? 3'd3 : 3'd4, c, 1'b1, rnd4(), rnd1(), op == 4'd5);
      if (op == 4'd5) return;
    end
    c = '0; c.regw = 1'b1; c.regdst = (op == 4'd0); c.m2r = (op == 4'd4);
    push(3'd5, c, rnd1(), rnd4(), rnd1(), 1'b1);
  endtask

  // Drive every pending cycle and compare the DUT against it.
  task automatic run_plan();
    cyc_t r;
    while (plan.size() > 0) begin
      r = plan.pop_front();
      reset     = r.rst;
      opcode    = r.opc;
      zero      = r.z;
      mem_ready = r.rdy;
      @(negedge clk);
      check_eq("state", {29'd0, state}, {29'd0, r.st});
      check_eq("ctl", {15'd0, ctl_obs}, {15'd0, r.ctl});
      check_eq("retired", {16'd0, retired}, {16'd0, r.ret});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] t;
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    push_reset();
    push_reset();
    run_plan();

    // R-type, zero wait states.
    add_instr(4'd0, 0, 0, 1'b0);
    // lw with two memory wait cycles.
    add_instr(4'd4, 0, 2, 1'b0);
    // beq taken and not taken.
    add_instr(4'd6, 0, 0, 1'b1);
    add_instr(4'd6, 0, 0, 1'b0);
    // j then illegal.
    add_instr(4'd7, 0, 0, 1'b0);
    add_instr(4'd10, 0, 0, 1'b0);
    run_plan();

    // sw interrupted by two reset cycles in the middle of MEM_WR.
    add_instr(4'd5, 0, 3, 1'b0);
    plan.delete(plan.size() - 1);
    plan.delete(plan.size() - 1);
    push_reset();
    push_reset();
    add_instr(4'd1, 1, 0, 1'b0);
    run_plan();

    // Randomized instruction mix with random wait states.
    for (int n = 0; n < 400; n++) begin
      t = $urandom_range(0, 9);
      op = (t > 32'd7) ? (4'd8 | rnd4()) : t[3:0];
      add_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rnd1());
      run_plan();
    end

    // Counter wrap: 65536 back-to-back jumps from a fresh reset.
    push_reset();
    run_plan();
    for (int n = 0; n < 65536; n++) begin
      add_instr(4'd7, 0, 0, 1'b0);
      run_plan();
    end
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_eq("wrap", {16'd0, retired}, 32'd0);
    check_eq("wrap_state", {29'd0, state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
